id_stage_pipe: RTL and testbench

//  Parametrised decode/register-read stage between fetch and execute of the pipelined RV32I core.

---
 rtl/riscv_pkg.sv | 59 +++++
 rtl/id_decode.sv | 79 +++++++
 rtl/id_stage_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, control bundle and immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int CTRL_W = 13;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;
  localparam logic [3:0] ALU_ADDPC = 4'd11;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;

  // spare is the top bit of the 13-bit bundle; always driven 0.
  typedef struct packed {
    logic       spare;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic       mem_read;
  } id_ctrl_t;

  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3,
                                                input logic       funct7b5,
                                                input logic       allow_sub);
    case (funct3)
      3'b000:  alu_from_funct = (allow_sub && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_funct = ALU_SLL;
      3'b010:  alu_from_funct = ALU_SLT;
      3'b011:  alu_from_funct = ALU_SLTU;
      3'b100:  alu_from_funct = ALU_XOR;
      3'b101:  alu_from_funct = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_funct = ALU_OR;
      default: alu_from_funct = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational main/ALU decoder: opcode, funct3, funct7[5] -> control bundle, immediate format, illegal flag.
module id_decode
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output id_ctrl_t   ctrl,
  output imm_src_e   imm_src,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    illegal = 1'b0;
    case (op)
      OP_LOAD: begin
        ctrl.result_src = 2'b01;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_STORE: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
        imm_src          = IMM_S;
      end
      OP_REG: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_from_funct(funct3, funct7b5, 1'b1);
      end
      OP_IMM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = alu_from_funct(funct3, funct7b5, 1'b0);
      end
      OP_BRANCH: begin
        // Comparison flavour rides on the ALU code: equality via SUB, signed/unsigned via SLT/SLTU.
        ctrl.branch = 1'b1;
        imm_src     = IMM_B;
        case (funct3[2:1])
          2'b10:   ctrl.alu_control = ALU_SLT;
          2'b11:   ctrl.alu_control = ALU_SLTU;
          default: ctrl.alu_control = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        ctrl.result_src = 2'b10;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.result_src  = 2'b10;
        ctrl.reg_write   = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADD;
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_COPYB;
        imm_src          = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        ctrl.alu_control = ALU_ADDPC;
        imm_src          = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode/register-read stage with valid/ready handshake, 2-entry skid buffer and flush.
// Optional macro ID_WB_BYPASS_EN: forward writeback data on capture and into held entries.
module id_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_pc_plus4,
  input  logic              flush,
  output logic [4:0]        rf_ra1,
  output logic [4:0]        rf_ra2,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [4:0]        hz_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_r1,
  output logic [XLEN-1:0]   out_r2,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc_plus4,
  output logic              out_illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  typedef struct packed {
    id_ctrl_t        ctrl;
    logic            illegal;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
  } entry_t;

  occ_e     state_reg, state_next;
  entry_t   main_reg, main_next, main_snoop;
  entry_t   skid_reg, skid_next, skid_snoop;
  entry_t   in_entry;
  logic     in_ready_reg;
  id_ctrl_t dec_ctrl;
  imm_src_e dec_imm_src;
  logic     dec_illegal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] in_r1, in_r2;
  logic     accept, xfer;

  assign rf_ra1 = in_instr[19:15];
  assign rf_ra2 = in_instr[24:20];
  assign hz_rd  = in_instr[11:7];

  id_decode u_decode (
    .op      (in_instr[6:0]),
    .funct3  (in_instr[14:12]),
    .funct7b5(in_instr[30]),
    .ctrl    (dec_ctrl),
    .imm_src (dec_imm_src),
    .illegal (dec_illegal)
  );

  always_comb begin
    imm32 = '0;
    case (dec_imm_src)
      IMM_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      IMM_U:   imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

`ifdef ID_WB_BYPASS_EN
  function automatic logic [XLEN-1:0] fwd(input logic [4:0]      rs,
                                          input logic [XLEN-1:0] cur,
                                          input logic            we,
                                          input logic [4:0]      wrd,
                                          input logic [XLEN-1:0] wdata);
    return (rs != 5'd0 && we && wrd == rs) ? wdata : cur;
  endfunction

  always_comb begin
    in_r1         = fwd(rf_ra1, rf_rd1, wb_we, wb_rd, wb_data);
    in_r2         = fwd(rf_ra2, rf_rd2, wb_we, wb_rd, wb_data);
    main_snoop    = main_reg;
    skid_snoop    = skid_reg;
    main_snoop.r1 = fwd(main_reg.rs1, main_reg.r1, wb_we, wb_rd, wb_data);
    main_snoop.r2 = fwd(main_reg.rs2, main_reg.r2, wb_we, wb_rd, wb_data);
    skid_snoop.r1 = fwd(skid_reg.rs1, skid_reg.r1, wb_we, wb_rd, wb_data);
    skid_snoop.r2 = fwd(skid_reg.rs2, skid_reg.r2, wb_we, wb_rd, wb_data);
  end
`else
  // Without forwarding the hazard unit guarantees operands; writeback ports are intentionally idle.
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};

  always_comb begin
    in_r1      = rf_rd1;
    in_r2      = rf_rd2;
    main_snoop = main_reg;
    skid_snoop = skid_reg;
  end
`endif

  always_comb begin
    in_entry          = '0;
    in_entry.ctrl     = dec_ctrl;
    if (in_instr[11:7] == 5'd0) in_entry.ctrl.reg_write = 1'b0;
    in_entry.illegal  = dec_illegal;
    in_entry.rs1      = in_instr[19:15];
    in_entry.rs2      = in_instr[24:20];
    in_entry.rd       = in_instr[11:7];
    in_entry.r1       = in_r1;
    in_entry.r2       = in_r2;
    in_entry.imm      = XLEN'($signed(imm32));
    in_entry.pc       = in_pc;
    in_entry.pc_plus4 = in_pc_plus4;
  end

  assign accept = in_valid && in_ready_reg;
  assign xfer   = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_snoop;
    skid_next  = skid_snoop;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_next  = in_entry;
        end
      end
      ONE: begin
        if (accept && !xfer) begin
          state_next = FULL;
          skid_next  = in_entry;
        end else if (accept && xfer) begin
          main_next = in_entry;
        end else if (xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          state_next = ONE;
          main_next  = skid_snoop;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) state_next = EMPTY;
    // An empty main slot must never present write strobes downstream.
    if (state_next == EMPTY) begin
      main_next.ctrl    = '0;
      main_next.illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != FULL);
    end
  end

  assign in_ready     = in_ready_reg;
  assign out_valid    = (state_reg != EMPTY);
  assign out_ctrl     = main_reg.ctrl;
  assign out_illegal  = main_reg.illegal;
  assign out_r1       = main_reg.r1;
  assign out_r2       = main_reg.r2;
  assign out_rs1      = main_reg.rs1;
  assign out_rs2      = main_reg.rs2;
  assign out_rd       = main_reg.rd;
  assign out_imm      = main_reg.imm;
  assign out_pc       = main_reg.pc;
  assign out_pc_plus4 = main_reg.pc_plus4;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe: reset, decode, skid/backpressure, flush, bypass.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, wb_we, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr, in_pc, in_pc_plus4;
  logic [4:0]  rf_ra1, rf_ra2, wb_rd, hz_rd, out_rs1, out_rs2, out_rd;
  logic [31:0] rf_rd1, rf_rd2, wb_data;
  logic [12:0] out_ctrl;
  logic [31:0] out_r1, out_r2, out_imm, out_pc, out_pc_plus4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Register file model: each register holds a recognisable tagged value.
  assign rf_rd1 = 32'h1000_0000 | {27'd0, rf_ra1};
  assign rf_rd2 = 32'h2000_0000 | {27'd0, rf_ra2};

  id_stage_pipe #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .flush(flush),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .hz_rd(hz_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_r1(out_r1), .out_r2(out_r2), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_illegal(out_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0; in_pc_plus4 = 32'd0;
    step(); step();
    $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_checks++; if (out_ctrl !== 13'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", out_ctrl); end
    n_checks++; if ({out_r1, out_imm, out_pc} !== 96'd0) begin n_fail++; $display("FAIL reset_payload: got %h expected 0", {out_r1, out_imm, out_pc}); end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0070_0293; in_pc = 32'h100; in_pc_plus4 = 32'h104;
    #1;
    n_checks++; if (hz_rd !== 5'd5) begin n_fail++; $display("FAIL addi_hz_rd: got %0d expected 5", hz_rd); end
    n_checks++; if (rf_ra1 !== 5'd0) begin n_fail++; $display("FAIL addi_ra1: got %0d expected 0", rf_ra1); end
    step(); in_valid = 1'b0;
    $display("addi: valid=%0b rd=%0d imm=%h ctrl=%h", out_valid, out_rd, out_imm, out_ctrl);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0b expected 1", out_valid); end
    n_checks++; if (out_imm !== 32'd7) begin n_fail++; $display("FAIL addi_imm: got %h expected 7", out_imm); end
    n_checks++; if (out_rd !== 5'd5) begin n_fail++; $display("FAIL addi_rd: got %0d expected 5", out_rd); end
    n_checks++; if (out_ctrl !== 13'h180) begin n_fail++; $display("FAIL addi_ctrl: got %h expected 180", out_ctrl); end
    n_checks++; if ({out_pc, out_pc_plus4} !== {32'h100, 32'h104}) begin n_fail++; $display("FAIL addi_pc: got %h/%h expected 100/104", out_pc, out_pc_plus4); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %0b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h200;
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %0b expected 1", in_ready); end
    in_instr = 32'h0020_0113; in_pc = 32'h204;
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %0b expected 0", in_ready); end
    in_instr = 32'h0030_0193; in_pc = 32'h208;
    step();
    $display("b2b stalled: in_ready=%0b out_rd=%0d", in_ready, out_rd);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_hold: got %0b expected 0", in_ready); end
    n_checks++; if ({out_valid, out_rd, out_imm} !== {1'b1, 5'd1, 32'd1}) begin n_fail++; $display("FAIL b2b_stable: got rd=%0d imm=%h expected rd=1 imm=1", out_rd, out_imm); end
    out_ready = 1'b1;
    step();
    $display("b2b out1: rd=%0d pc=%h", out_rd, out_pc);
    n_checks++; if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd2, 32'h204}) begin n_fail++; $display("FAIL b2b_second: got rd=%0d pc=%h expected rd=2 pc=204", out_rd, out_pc); end
    step(); in_valid = 1'b0;
    $display("b2b out2: rd=%0d pc=%h", out_rd, out_pc);
    n_checks++; if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd3, 32'h208}) begin n_fail++; $display("FAIL b2b_third: got rd=%0d pc=%h expected rd=3 pc=208", out_rd, out_pc); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0010_0093; step();
    in_instr = 32'h0020_0113; step();
    in_instr = 32'h0030_0193; flush = 1'b1;
    step(); flush = 1'b0; in_valid = 1'b0;
    $display("flush full: out_valid=%0b in_ready=%0b ctrl=%h", out_valid, in_ready, out_ctrl);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b expected 1", in_ready); end
    n_checks++; if ({out_ctrl[9], out_ctrl[7]} !== 2'b00) begin n_fail++; $display("FAIL flush_strobes: got %b expected 00", {out_ctrl[9], out_ctrl[7]}); end
    out_ready = 1'b1;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %0b expected 0", out_valid); end
    in_valid = 1'b1; in_instr = 32'h0010_0093; flush = 1'b1;
    step(); idle();
    $display("flush empty+accept: out_valid=%0b", out_valid);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept: got %0b expected 0", out_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] instrs [9];
    logic [12:0] ctrls  [9];
    logic [31:0] imms   [9];
    logic        chk_imm[9];
    logic        ills   [9];
    instrs = '{32'h0000_00FF, 32'h0020_8033, 32'h0020_81B3, 32'h4020_81B3, 32'h0020_A423,
               32'hFE20_8EE3, 32'h1234_52B7, 32'h0080_00EF, 32'hFFF0_A283};
    ctrls  = '{13'h000, 13'h000, 13'h080, 13'h082, 13'h300, 13'h022, 13'h194, 13'h8C0, 13'h581};
    imms   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'hFFFF_FFFC, 32'h1234_5000, 32'h8, 32'hFFFF_FFFF};
    chk_imm = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ills   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr = instrs[i];
      step(); in_valid = 1'b0;
      $display("decode %h: ctrl=%h imm=%h illegal=%0b", instrs[i], out_ctrl, out_imm, out_illegal);
      n_checks++; if (out_ctrl !== ctrls[i]) begin n_fail++; $display("FAIL decode_ctrl[%0d]: got %h expected %h", i, out_ctrl, ctrls[i]); end
      n_checks++; if (out_illegal !== ills[i]) begin n_fail++; $display("FAIL decode_illegal[%0d]: got %0b expected %0b", i, out_illegal, ills[i]); end
      if (chk_imm[i]) begin
        n_checks++; if (out_imm !== imms[i]) begin n_fail++; $display("FAIL decode_imm[%0d]: got %h expected %h", i, out_imm, imms[i]); end
      end
      step();
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_r1, exp_r2;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0020_81B3;
    step(); in_valid = 1'b0;
    n_checks++; if ({out_rs1, out_rs2, out_r1, out_r2} !== {5'd1, 5'd2, 32'h1000_0001, 32'h2000_0002}) begin n_fail++; $display("FAIL byp_capture: got r1=%h r2=%h expected 10000001/20000002", out_r1, out_r2); end
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_DEAD;
    step(); idle();
`ifdef ID_WB_BYPASS_EN
    exp_r1 = 32'h0000_DEAD;
`else
    exp_r1 = 32'h1000_0001;
`endif
    $display("bypass held: out_r1=%h out_r2=%h", out_r1, out_r2);
    n_checks++; if (out_r1 !== exp_r1) begin n_fail++; $display("FAIL byp_snoop_r1: got %h expected %h", out_r1, exp_r1); end
    n_checks++; if (out_r2 !== 32'h2000_0002) begin n_fail++; $display("FAIL byp_snoop_r2: got %h expected 20000002", out_r2); end
    out_ready = 1'b1; step();
    in_valid = 1'b1; in_instr = 32'h0020_81B3;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_BEEF;
    step(); idle();
`ifdef ID_WB_BYPASS_EN
    exp_r2 = 32'h0000_BEEF;
`else
    exp_r2 = 32'h2000_0002;
`endif
    $display("bypass capture: out_r1=%h out_r2=%h", out_r1, out_r2);
    n_checks++; if (out_r2 !== exp_r2) begin n_fail++; $display("FAIL byp_capture_r2: got %h expected %h", out_r2, exp_r2); end
    n_checks++; if (out_r1 !== 32'h1000_0001) begin n_fail++; $display("FAIL byp_capture_r1: got %h expected 10000001", out_r1); end
    step();
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h300; in_pc_plus4 = 32'h304; step();
    in_instr = 32'h0020_0113; in_pc = 32'h304; step();
    in_valid = 1'b0;
    n_checks++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL rstfull_pre: got %b expected 10", {out_valid, in_ready}); end
    reset = 1'b1;
    step(); reset = 1'b0;
    $display("reset in full: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rstfull_state: got %b expected 01", {out_valid, in_ready}); end
    n_checks++; if ({out_ctrl, out_illegal, out_rs1, out_rs2, out_rd} !== 29'd0) begin n_fail++; $display("FAIL rstfull_fields: got %h expected 0", {out_ctrl, out_illegal, out_rs1, out_rs2, out_rd}); end
    n_checks++; if ({out_r1, out_r2, out_imm, out_pc, out_pc_plus4} !== 160'd0) begin n_fail++; $display("FAIL rstfull_data: got %h expected 0", {out_r1, out_r2, out_imm, out_pc, out_pc_plus4}); end
    out_ready = 1'b1; step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_skid_gone: got %0b expected 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_flush();
    test_decode();
    test_bypass();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
